// File: rtl/mult_issue_queue.sv
// Reservation station for the pipelined multiply unit.
// Holds dispatched MUL/MULH ops in a collapsing queue (entry 0 = oldest),
// snoops the CDB for missing operands and issues the oldest ready op each cycle.
module mult_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_en,
    input  logic [DATA_W-1:0] disp_rs1_data,
    input  logic [TAG_W-1:0]  disp_rs1_tag,
    input  logic              disp_rs1_rdy,
    input  logic [DATA_W-1:0] disp_rs2_data,
    input  logic [TAG_W-1:0]  disp_rs2_tag,
    input  logic              disp_rs2_rdy,
    input  logic [2:0]        disp_funct3,
    input  logic [TAG_W-1:0]  disp_rd_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              full,
    output logic              queue_en,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [2:0]        funct3,
    output logic [TAG_W-1:0]  tag_in,
    output logic              tag_in_valid
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              rdy;
    } opnd_t;

    typedef struct packed {
        opnd_t             rs1;
        opnd_t             rs2;
        logic [2:0]        funct3;
        logic [TAG_W-1:0]  rd_tag;
    } payload_t;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    payload_t         pl     [DEPTH];
    payload_t         pl_nxt [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             iss_en;
    logic [IW-1:0]    iss_idx;
    logic             disp_acc;
    int               wr_idx;
    payload_t         disp_pl;

    // A waiting operand whose producer tag is on the CDB captures the value.
    function automatic opnd_t wake(input opnd_t o, input logic cv,
                                   input logic [TAG_W-1:0] ct,
                                   input logic [DATA_W-1:0] cd);
        opnd_t r;
        r = o;
        if (cv && !o.rdy && (o.tag == ct)) begin
            r.data = cd;
            r.rdy  = 1'b1;
        end
        return r;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign disp_acc = disp_en & ~full & ~flush;

    // Oldest-first select among entries whose operands are both ready (registered state only)
    always_comb begin
        iss_en  = 1'b0;
        iss_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld[i] && pl[i].rs1.rdy && pl[i].rs2.rdy) begin
                iss_en  = 1'b1;
                iss_idx = IW'(i);
            end
        end
    end

    // Issue port: selected entry, or all zero when nothing is ready
    always_comb begin
        queue_en     = iss_en;
        tag_in_valid = iss_en;
        op1          = '0;
        op2          = '0;
        funct3       = '0;
        tag_in       = '0;
        if (iss_en) begin
            op1    = pl[iss_idx].rs1.data;
            op2    = pl[iss_idx].rs2.data;
            funct3 = pl[iss_idx].funct3;
            tag_in = pl[iss_idx].rd_tag;
        end
    end

    // Incoming op with CDB bypass; lands behind the last surviving entry
    always_comb begin
        wr_idx         = int'(count) - (iss_en ? 1 : 0);
        disp_pl.rs1    = wake(opnd_t'({disp_rs1_data, disp_rs1_tag, disp_rs1_rdy}),
                              cdb_valid, cdb_tag, cdb_data);
        disp_pl.rs2    = wake(opnd_t'({disp_rs2_data, disp_rs2_tag, disp_rs2_rdy}),
                              cdb_valid, cdb_tag, cdb_data);
        disp_pl.funct3 = disp_funct3;
        disp_pl.rd_tag = disp_rd_tag;
    end

    // Next queue image: collapse above the issued slot, wake operands, append dispatch
    always_comb begin
        vld_nxt = vld;
        for (int i = 0; i < DEPTH; i++) begin
            pl_nxt[i] = pl[i];
            if (iss_en && (i >= int'(iss_idx))) begin
                if (i == DEPTH - 1) begin
                    vld_nxt[i] = 1'b0;
                end else begin
                    vld_nxt[i] = vld[(i < DEPTH - 1) ? i + 1 : i];
                    pl_nxt[i]  = pl[(i < DEPTH - 1) ? i + 1 : i];
                end
            end
            pl_nxt[i].rs1 = wake(pl_nxt[i].rs1, cdb_valid, cdb_tag, cdb_data);
            pl_nxt[i].rs2 = wake(pl_nxt[i].rs2, cdb_valid, cdb_tag, cdb_data);
            if (disp_acc && (i == wr_idx)) begin
                vld_nxt[i] = 1'b1;
                pl_nxt[i]  = disp_pl;
            end
        end
        count_nxt = count - CW'(iss_en) + CW'(disp_acc);
        if (flush) begin
            vld_nxt   = '0;
            count_nxt = '0;
        end
    end

    // Control state: valid bits and occupancy are the only reset-sensitive registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            count <= '0;
        end else begin
            vld   <= vld_nxt;
            count <= count_nxt;
        end
    end

    // Payload storage: only ever observed through a valid entry, so it carries no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            pl[i] <= pl_nxt[i];
        end
    end

endmodule
